// File: rtl/multicycle_main_control.sv
// multicycle_main_control: FETCH/DECODE/EXEC/MEM/WB control FSM with memory handshake, timeout and sticky traps
module multicycle_main_control #(
  parameter int OPCODE_W    = 7,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                branch_taken,
  output logic                mem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                ALUSrc,
  output logic                alu_a_pc,
  output logic [1:0]          Memto_Reg,
  output logic                Reg_Write,
  output logic                Mem_read,
  output logic                Mem_write,
  output logic                Branch,
  output logic [1:0]          ALU_OP,
  output logic                salto_incon,
  output logic                flag_direccion,
  output logic [2:0]          state_o,
  output logic                illegal_instr,
  output logic                bus_error
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd7;
  localparam logic [3:0] C_R = 4'd0, C_I = 4'd1, C_LD = 4'd2, C_ST = 4'd3, C_BR = 4'd4, C_JAL = 4'd5,
                         C_JALR = 4'd6, C_LUI = 4'd7, C_AUIPC = 4'd8, C_BAD = 4'd15;
  logic [2:0]       state_q, state_d;
  logic [3:0]       cls_q, cls_d, dec_cls;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d, bus_error_q, bus_error_d;
  logic             waiting, timeout, ex, wb, jump;
  always_comb begin
    dec_cls = opcode == OPCODE_W'(7'b0110011) ? C_R :
              opcode == OPCODE_W'(7'b0010011) ? C_I :
              opcode == OPCODE_W'(7'b0000011) ? C_LD :
              opcode == OPCODE_W'(7'b0100011) ? C_ST :
              opcode == OPCODE_W'(7'b1100011) ? C_BR :
              opcode == OPCODE_W'(7'b1101111) ? C_JAL :
              opcode == OPCODE_W'(7'b1100111) ? C_JALR :
              opcode == OPCODE_W'(7'b0110111) ? C_LUI :
              opcode == OPCODE_W'(7'b0010111) ? C_AUIPC : C_BAD;
    waiting = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
    // the TIMEOUT_CYC-th consecutive unanswered cycle is the one that traps
    timeout = waiting && cnt_q == CNT_W'(TIMEOUT_CYC - 1);
    cnt_d   = (waiting && !timeout) ? cnt_q + 1'b1 : '0;
    cls_d   = state_q == S_DECODE ? dec_cls : cls_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
      S_DECODE: state_d = dec_cls == C_BAD ? S_TRAP : S_EXEC;
      S_EXEC:   state_d = cls_q == C_BR ? S_FETCH : (cls_q == C_LD || cls_q == C_ST) ? S_MEM : S_WB;
      S_MEM:    state_d = mem_ready ? (cls_q == C_ST ? S_FETCH : S_WB) : timeout ? S_TRAP : S_MEM;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_TRAP;
    endcase
    illegal_d   = illegal_q | (state_q == S_DECODE && dec_cls == C_BAD);
    bus_error_d = bus_error_q | timeout;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      cls_q       <= C_R;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end
  always_comb begin
    ex             = state_q == S_EXEC || state_q == S_MEM;
    wb             = state_q == S_WB;
    jump           = cls_q == C_JAL || cls_q == C_JALR;
    mem_req        = state_q == S_FETCH || state_q == S_MEM;
    ir_write       = state_q == S_FETCH && mem_ready;
    Mem_read       = state_q == S_FETCH || (state_q == S_MEM && cls_q == C_LD);
    Mem_write      = state_q == S_MEM && cls_q == C_ST;
    ALUSrc         = ex && (cls_q == C_I || cls_q == C_LD || cls_q == C_ST || cls_q == C_AUIPC);
    alu_a_pc       = ex && cls_q == C_AUIPC;
    ALU_OP         = !ex ? 2'b00 : (cls_q == C_R || cls_q == C_I) ? 2'b10 :
                     (cls_q == C_BR || cls_q == C_LUI || jump) ? 2'b01 : 2'b00;
    Memto_Reg      = !wb ? 2'b00 : cls_q == C_LD ? 2'b01 : jump ? 2'b10 : cls_q == C_LUI ? 2'b11 : 2'b00;
    Reg_Write      = wb;
    pc_write       = wb || (state_q == S_EXEC && cls_q == C_BR) || (Mem_write && mem_ready);
    Branch         = (state_q == S_EXEC && cls_q == C_BR && branch_taken) || (wb && jump);
    salto_incon    = wb && jump;
    flag_direccion = wb && cls_q == C_JALR;
    state_o        = state_q;
    illegal_instr  = illegal_q;
    bus_error      = bus_error_q;
  end
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: per-cycle expected outputs queued by stimulus, popped and compared by a monitor
module tb_multicycle_main_control;
  logic clk = 0, rst_n = 0, mem_ready = 0, branch_taken = 0;
  logic [6:0] opcode = '0;
  logic mem_req, ir_write, pc_write, ALUSrc, alu_a_pc, Reg_Write, Mem_read, Mem_write, Branch;
  logic salto_incon, flag_direccion, illegal_instr, bus_error;
  logic [1:0] Memto_Reg, ALU_OP;
  logic [2:0] state_o;

  multicycle_main_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .ir_write(ir_write), .pc_write(pc_write), .ALUSrc(ALUSrc), .alu_a_pc(alu_a_pc),
    .Memto_Reg(Memto_Reg), .Reg_Write(Reg_Write), .Mem_read(Mem_read), .Mem_write(Mem_write),
    .Branch(Branch), .ALU_OP(ALU_OP), .salto_incon(salto_incon), .flag_direccion(flag_direccion),
    .state_o(state_o), .illegal_instr(illegal_instr), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic mreq, irw, pcw, asrc, apc;
    logic [1:0] m2r;
    logic rw, mrd, mwr, br;
    logic [1:0] aop;
    logic sj, fd, ill, berr;
  } o_t;
  typedef struct { o_t v; string nm; } ent_t;

  ent_t q[$];
  int tests = 0, fails = 0;
  logic ei = 0, eb = 0;
  o_t got;
  assign got = {state_o, mem_req, ir_write, pc_write, ALUSrc, alu_a_pc, Memto_Reg, Reg_Write, Mem_read,
                Mem_write, Branch, ALU_OP, salto_incon, flag_direccion, illegal_instr, bus_error};

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_BAD = 7'b1111111;

  function automatic o_t mk(logic [2:0] st, logic mreq, irw, pcw, asrc, apc, logic [1:0] m2r,
                            logic rw, mrd, mwr, br, logic [1:0] aop, logic sj, fd);
    return {st, mreq, irw, pcw, asrc, apc, m2r, rw, mrd, mwr, br, aop, sj, fd, ei, eb};
  endfunction
  function automatic o_t fet_o(logic irw);
    return mk(3'd0, 1, irw, 0, 0, 0, 2'd0, 0, 1, 0, 0, 2'd0, 0, 0);
  endfunction
  function automatic o_t dec_o();
    return mk(3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0);
  endfunction
  function automatic o_t trap_o();
    return mk(3'd7, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0);
  endfunction

  task automatic cyc(input logic rn, mr, bt, input logic [6:0] op, input o_t e, input string nm);
    rst_n = rn; mem_ready = mr; branch_taken = bt; opcode = op;
    q.push_back('{e, nm});
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input logic [6:0] op, input o_t ex, input o_t w, input string nm);
    cyc(1, 1, 0, op, fet_o(1), {nm, "_fetch"});
    cyc(1, 1, 0, op, dec_o(), {nm, "_decode"});
    cyc(1, 1, 0, op, ex, {nm, "_exec"});
    cyc(1, 1, 0, op, w, {nm, "_wb"});
  endtask

  always @(negedge clk) begin
    ent_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      tests++;
      if (got !== x.v) begin
        fails++;
        $display("FAIL %s got=%h exp=%h", x.nm, got, x.v);
      end
    end
  end

  o_t ld_m, st_m_wait, st_m_done, r_ex, wb_alu;

  initial begin
    @(posedge clk);
    #1;
    cyc(0, 0, 0, '0, fet_o(0), "reset_fetch");
    r_ex   = mk(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd2, 0, 0);
    wb_alu = mk(3'd4, 0, 0, 1, 0, 0, 2'd0, 1, 0, 0, 0, 2'd0, 0, 0);
    run4(OP_R, r_ex, wb_alu, "rtype");
    run4(OP_I, mk(3'd2, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 2'd2, 0, 0), wb_alu, "itype");
    run4(OP_LUI, mk(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd1, 0, 0),
         mk(3'd4, 0, 0, 1, 0, 0, 2'd3, 1, 0, 0, 0, 2'd0, 0, 0), "lui");
    run4(OP_AUIPC, mk(3'd2, 0, 0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0), wb_alu, "auipc");
    run4(OP_JAL, mk(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd1, 0, 0),
         mk(3'd4, 0, 0, 1, 0, 0, 2'd2, 1, 0, 0, 1, 2'd0, 1, 0), "jal");
    run4(OP_JALR, mk(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd1, 0, 0),
         mk(3'd4, 0, 0, 1, 0, 0, 2'd2, 1, 0, 0, 1, 2'd0, 1, 1), "jalr");
    for (int t = 1; t >= 0; t--) begin
      cyc(1, 1, 0, OP_BR, fet_o(1), "br_fetch");
      cyc(1, 1, 0, OP_BR, dec_o(), "br_decode");
      cyc(1, 1, t[0], OP_BR, mk(3'd2, 0, 0, 1, 0, 0, 2'd0, 0, 0, 0, t[0], 2'd1, 0, 0),
          t[0] ? "br_taken_exec" : "br_not_taken_exec");
    end
    st_m_wait = mk(3'd3, 1, 0, 0, 1, 0, 2'd0, 0, 0, 1, 0, 2'd0, 0, 0);
    st_m_done = mk(3'd3, 1, 0, 1, 1, 0, 2'd0, 0, 0, 1, 0, 2'd0, 0, 0);
    for (int w = 0; w < 2; w++) begin
      cyc(1, 1, 0, OP_ST, fet_o(1), "st_fetch");
      cyc(1, 1, 0, OP_ST, dec_o(), "st_decode");
      cyc(1, 1, 0, OP_ST, mk(3'd2, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0), "st_exec");
      if (w == 1) cyc(1, 0, 0, OP_ST, st_m_wait, "st_mem_wait");
      cyc(1, 1, 0, OP_ST, st_m_done, "st_mem_done");
    end
    ld_m = mk(3'd3, 1, 0, 0, 1, 0, 2'd0, 0, 1, 0, 0, 2'd0, 0, 0);
    cyc(1, 1, 0, OP_LD, fet_o(1), "ld_fetch");
    cyc(1, 1, 0, OP_LD, dec_o(), "ld_decode");
    cyc(1, 1, 0, OP_LD, mk(3'd2, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0), "ld_exec");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, OP_LD, ld_m, "ld_mem_wait");
    cyc(1, 1, 0, OP_LD, ld_m, "ld_mem_done");
    cyc(1, 1, 0, OP_LD, mk(3'd4, 0, 0, 1, 0, 0, 2'd1, 1, 0, 0, 0, 2'd0, 0, 0), "ld_wb");
    cyc(1, 1, 0, OP_LD, fet_o(1), "ld_abort_fetch");
    cyc(1, 1, 0, OP_LD, dec_o(), "ld_abort_decode");
    cyc(1, 1, 0, OP_LD, mk(3'd2, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0), "ld_abort_exec");
    cyc(0, 0, 0, OP_LD, ld_m, "ld_abort_mem_rst");
    cyc(1, 0, 0, OP_R, fet_o(0), "after_abort_fetch");
    run4(OP_R, r_ex, wb_alu, "r_after_abort");
    cyc(1, 1, 0, OP_BAD, fet_o(1), "bad_fetch");
    cyc(1, 1, 0, OP_BAD, dec_o(), "bad_decode");
    ei = 1;
    cyc(1, 1, 0, OP_BAD, trap_o(), "bad_trap");
    cyc(1, 1, 0, OP_R, trap_o(), "bad_trap_hold");
    cyc(0, 1, 0, OP_R, trap_o(), "bad_trap_rst");
    ei = 0;
    run4(OP_R, r_ex, wb_alu, "r_after_illegal");
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, OP_R, fet_o(0), "to_fetch_wait");
    eb = 1;
    cyc(1, 1, 0, OP_R, trap_o(), "to_trap");
    cyc(0, 1, 0, OP_R, trap_o(), "to_trap_rst");
    eb = 0;
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, OP_R, fet_o(0), "edge_fetch_wait");
    cyc(1, 1, 0, OP_R, fet_o(1), "edge_ready_last");
    cyc(1, 1, 0, OP_R, dec_o(), "edge_decode");
    cyc(1, 1, 0, OP_R, r_ex, "edge_exec");
    cyc(1, 1, 0, OP_R, wb_alu, "edge_wb");
    cyc(1, 1, 0, OP_LD, fet_o(1), "mto_fetch");
    cyc(1, 1, 0, OP_LD, dec_o(), "mto_decode");
    cyc(1, 1, 0, OP_LD, mk(3'd2, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0), "mto_exec");
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, OP_LD, ld_m, "mto_mem_wait");
    eb = 1;
    cyc(1, 0, 0, OP_LD, trap_o(), "mto_trap");
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d exp=0 pending", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
